mcdf_arbiter: RTL and testbench
===============================

Name: mcdf_arbiter

Overview:
- Three-channel packet arbiter between the slave-node FIFOs and the downstream formatter.
- Selects one channel with available data, using per-channel priority with a round-robin tie-break.
- Requests the formatter and, once granted, drains exactly one packet of the configured length from the chosen slave node using its fetch strobe.
- Presents the packet words, channel id, length and end-of-packet marker to the formatter.

Parameters:
- DATA_W, 32, width of the data word carried from slave node to formatter.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- ch_valid_i  in  3  per-channel FIFO non-empty (slave valid_o)
- ch0_data_i, ch1_data_i, ch2_data_i  in  DATA_W each  FIFO head word from slave data_o
- ch_fetch_o  out  3  one-hot pop strobe to the slave node fetch input
- ch_en_i  in  3  channel enable from register block
- ch_prio_i  in  6  2 bits per channel ([1:0]=ch0); 0 is highest priority
- ch_len_i  in  9  3 bits per channel: 0->4, 1->8, 2->16, 3..7->32 words
- fmt_req_o  out  1  packet request to formatter
- fmt_grant_i  in  1  formatter accepts request
- fmt_chid_o  out  2  granted channel id
- fmt_len_o  out  6  packet length in words (4/8/16/32)
- fmt_ready_i  in  1  formatter can take a data word this cycle
- fmt_valid_o  out  1  data word valid
- fmt_data_o  out  DATA_W  data word
- fmt_end_o  out  1  last word of packet, qualified by fmt_valid_o
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: async on rst_n_i low; all outputs 0; state IDLE; rr_last=2 (ch0 wins the first tie); word counter 0. Reset mid-packet aborts silently, with no fetch issued after reset assertion.
- Eligible channel k: ch_en_i[k] && ch_valid_i[k].
- IDLE:
  - If any channel is eligible: winner = lowest ch_prio value among eligible channels.
  - Tie among equal priorities: the first eligible channel scanning rr_last+1, rr_last+2, rr_last+3 (mod 3).
  - Latch chid and decoded length; go REQ next cycle.
- REQ:
  - fmt_req_o=1; fmt_chid_o and fmt_len_o are stable, registered from the latch.
  - Hold until fmt_grant_i=1, then go SEND.
  - fmt_grant_i sampled outside REQ is ignored.
  - Latched channel/length do not change even if ch_en/prio/len or valid change while waiting.
- SEND:
  - Transfer condition: ch_valid_i[chid] && fmt_ready_i.
  - On transfer: ch_fetch_o[chid]=1, fmt_valid_o=1, fmt_data_o = data of chid. These are combinational from inputs, zero latency, and the FIFO pops at that edge. Counter increments.
  - No transfer (channel empty or formatter not ready): fetch=0, fmt_valid_o=0, fmt_data_o=0. The packet stalls but is never aborted.
  - On the transfer where counter == len-1: fmt_end_o=1; next state IDLE; counter cleared; rr_last=chid.
  - fmt_req_o=0 in SEND.
- Disabling ch_en_i of the active channel during REQ/SEND does not abort; the packet completes.
- Back-to-back: IDLE arbitration occurs the cycle after fmt_end_o, so there is a minimum of 1 IDLE cycle between packets.
- ch_fetch_o is at most one-hot; fetch is never asserted to a channel whose ch_valid_i=0.
- fmt_chid_o/fmt_len_o hold their last values through SEND and return to 0 in IDLE.
- Counter is 6 bits; wrap is not possible because length is at most 32.

Test Plan:
- Single channel: ch0 enabled, len=0, prio=0, FIFO holds 4 words A0..A3; grant after 2 cycles -> fmt_req_o for 2 cycles with chid=0, len=4; then 4 consecutive fmt_valid words A0..A3 with 4 fetch pulses on bit0; fmt_end_o on A3; busy_o drops the next cycle.
- Priority: ch0 prio=2, ch1 prio=1, ch2 prio=3, all valid -> order ch1, ch0, ch2 while all remain valid.
- Round-robin: all prio=0, all valid, len=4 -> grants ch0, ch1, ch2, ch0; fetch is never asserted to a non-granted channel.
- Backpressure/underflow: ch2 len=1 (8 words); toggle fmt_ready_i every cycle and empty the FIFO after word 5 for 3 cycles -> exactly 8 fetches, no fetch while ch_valid_i[2]=0, fmt_end_o only on word 8, data order preserved.
- Enable/config change: start ch1 packet (len=16); deassert ch_en_i[1] and change ch_len_i after word 3 -> 16 words still sent; ch1 not selected afterwards.
- Reset mid-packet: assert rst_n_i low after word 2 of an 8-word packet -> all outputs 0 asynchronously; after release ch0 wins a prio tie; 0 fetches during reset.

Source files
------------

// File: rtl/mcdf_arbiter.sv
// Three-channel packet arbiter: picks a slave-node FIFO by priority with a
// round-robin tie-break, requests the formatter and streams one packet.
module mcdf_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [2:0]        ch_valid_i,
    input  logic [DATA_W-1:0] ch0_data_i,
    input  logic [DATA_W-1:0] ch1_data_i,
    input  logic [DATA_W-1:0] ch2_data_i,
    output logic [2:0]        ch_fetch_o,
    input  logic [2:0]        ch_en_i,
    input  logic [5:0]        ch_prio_i,
    input  logic [8:0]        ch_len_i,
    output logic              fmt_req_o,
    input  logic              fmt_grant_i,
    output logic [1:0]        fmt_chid_o,
    output logic [5:0]        fmt_len_o,
    input  logic              fmt_ready_i,
    output logic              fmt_valid_o,
    output logic [DATA_W-1:0] fmt_data_o,
    output logic              fmt_end_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

    state_t            state;
    logic [5:0]        cnt_q;
    logic [1:0]        rr_last;
    logic [2:0]        elig;
    logic [1:0]        prio_a [3];
    logic [2:0]        len_a  [3];
    logic [DATA_W-1:0] data_a [3];
    logic              win_vld;
    logic [1:0]        win_id;
    logic [1:0]        win_prio;
    logic [1:0]        scan;
    logic              xfer;
    logic              last;

    function automatic logic [5:0] decode_len(input logic [2:0] code);
        logic [5:0] len;
        case (code)
            3'd0:    len = 6'd4;
            3'd1:    len = 6'd8;
            3'd2:    len = 6'd16;
            default: len = 6'd32;
        endcase
        return len;
    endfunction

    function automatic logic [1:0] next_ch(input logic [1:0] ch);
        return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
    endfunction

    assign elig      = ch_en_i & ch_valid_i;
    assign prio_a[0] = ch_prio_i[1:0];
    assign prio_a[1] = ch_prio_i[3:2];
    assign prio_a[2] = ch_prio_i[5:4];
    assign len_a[0]  = ch_len_i[2:0];
    assign len_a[1]  = ch_len_i[5:3];
    assign len_a[2]  = ch_len_i[8:6];
    assign data_a[0] = ch0_data_i;
    assign data_a[1] = ch1_data_i;
    assign data_a[2] = ch2_data_i;

    // Scan in round-robin order starting after rr_last; only a strictly
    // better priority displaces an earlier candidate, so ties go to the
    // first channel in rotation.
    always_comb begin
        win_vld  = 1'b0;
        win_id   = 2'd0;
        win_prio = 2'd3;
        scan     = rr_last;
        for (int i = 0; i < 3; i++) begin
            scan = next_ch(scan);
            if (elig[scan] && (!win_vld || prio_a[scan] < win_prio)) begin
                win_vld  = 1'b1;
                win_id   = scan;
                win_prio = prio_a[scan];
            end
        end
    end

    // The data path is combinational so the FIFO pops on the same edge the
    // formatter takes the word.
    assign xfer        = (state == SEND) && ch_valid_i[fmt_chid_o] && fmt_ready_i;
    assign last        = (cnt_q == fmt_len_o - 6'd1);
    assign ch_fetch_o  = xfer ? (3'b001 << fmt_chid_o) : 3'b000;
    assign fmt_valid_o = xfer;
    assign fmt_data_o  = xfer ? data_a[fmt_chid_o] : '0;
    assign fmt_end_o   = xfer && last;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            fmt_req_o  <= 1'b0;
            fmt_chid_o <= 2'd0;
            fmt_len_o  <= 6'd0;
            busy_o     <= 1'b0;
            cnt_q      <= 6'd0;
            rr_last    <= 2'd2;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state      <= REQ;
                        fmt_req_o  <= 1'b1;
                        fmt_chid_o <= win_id;
                        fmt_len_o  <= decode_len(len_a[win_id]);
                        busy_o     <= 1'b1;
                    end
                end
                REQ: begin
                    if (fmt_grant_i) begin
                        state     <= SEND;
                        fmt_req_o <= 1'b0;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (last) begin
                            state      <= IDLE;
                            cnt_q      <= 6'd0;
                            rr_last    <= fmt_chid_o;
                            fmt_chid_o <= 2'd0;
                            fmt_len_o  <= 6'd0;
                            busy_o     <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Directed bench for mcdf_arbiter: FIFO models feed the three channels, a
// monitor records fetches, grants and formatter words.
module tb_mcdf_arbiter;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n_i;
    logic [2:0]        ch_valid_i;
    logic [DATA_W-1:0] ch0_data_i, ch1_data_i, ch2_data_i;
    logic [2:0]        ch_fetch_o;
    logic [2:0]        ch_en_i;
    logic [5:0]        ch_prio_i;
    logic [8:0]        ch_len_i;
    logic              fmt_req_o, fmt_grant_i;
    logic [1:0]        fmt_chid_o;
    logic [5:0]        fmt_len_o;
    logic              fmt_ready_i, fmt_valid_o;
    logic [DATA_W-1:0] fmt_data_o;
    logic              fmt_end_o, busy_o;

    logic              auto_grant, man_grant, flush;
    logic [2:0]        hold;
    logic [31:0]       mem [3][64];
    int                wr[3] = '{0, 0, 0};
    int                rd[3] = '{0, 0, 0};
    int                fetch_cnt[3] = '{0, 0, 0};
    int                bad_fetch = 0;
    logic [31:0]       out_data[$];
    logic              out_end[$];
    logic [1:0]        out_ch[$];
    logic [1:0]        grant_q[$];
    logic [46:0]       all_out;
    int                errors = 0;
    int                checks = 0;

    always #5 clk = ~clk;

    mcdf_arbiter #(.DATA_W(DATA_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .ch_valid_i(ch_valid_i),
        .ch0_data_i(ch0_data_i), .ch1_data_i(ch1_data_i), .ch2_data_i(ch2_data_i),
        .ch_fetch_o(ch_fetch_o), .ch_en_i(ch_en_i), .ch_prio_i(ch_prio_i),
        .ch_len_i(ch_len_i), .fmt_req_o(fmt_req_o), .fmt_grant_i(fmt_grant_i),
        .fmt_chid_o(fmt_chid_o), .fmt_len_o(fmt_len_o), .fmt_ready_i(fmt_ready_i),
        .fmt_valid_o(fmt_valid_o), .fmt_data_o(fmt_data_o), .fmt_end_o(fmt_end_o),
        .busy_o(busy_o)
    );

    assign fmt_grant_i = auto_grant ? fmt_req_o : man_grant;
    assign all_out = {fmt_req_o, fmt_valid_o, fmt_end_o, busy_o, ch_fetch_o,
                      fmt_chid_o, fmt_len_o, fmt_data_o};

    always_comb begin
        for (int k = 0; k < 3; k++) ch_valid_i[k] = (rd[k] < wr[k]) && !hold[k];
        ch0_data_i = mem[0][rd[0]];
        ch1_data_i = mem[1][rd[1]];
        ch2_data_i = mem[2][rd[2]];
    end

    // Slave FIFO pop plus recording of everything the formatter side sees.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (flush) rd[k] <= wr[k];
            else if (ch_fetch_o[k]) begin
                rd[k] <= rd[k] + 1;
                fetch_cnt[k] <= fetch_cnt[k] + 1;
            end
        end
        if (ch_fetch_o != 3'b000 &&
            (ch_fetch_o != (3'b001 << fmt_chid_o) || (ch_fetch_o & ~ch_valid_i) != 3'b000))
            bad_fetch <= bad_fetch + 1;
        if (fmt_valid_o) begin
            out_data.push_back(fmt_data_o);
            out_end.push_back(fmt_end_o);
            out_ch.push_back(fmt_chid_o);
        end
        if (fmt_req_o && fmt_grant_i) grant_q.push_back(fmt_chid_o);
    end

    function automatic logic [31:0] mkw(input int t, input int ch, input int n);
        return (32'(t) << 16) | (32'(ch) << 12) | 32'(n);
    endfunction

    task automatic push(input int k, input logic [31:0] w);
        mem[k][wr[k]] = w;
        wr[k] = wr[k] + 1;
    endtask

    task automatic wait_done(input int target, input int maxc, input string nm);
        int c = 0;
        while ((out_data.size() < target || busy_o) && c < maxc) begin
            @(negedge clk); #1; c++;
        end
        checks++;
        if (c >= maxc) begin
            errors++;
            $display("FAIL %s_timeout: words %0d, need %0d", nm, out_data.size(), target);
        end
    endtask

    task automatic wait_fetch(input int k, input int target, input int maxc, input string nm);
        int c = 0;
        while (fetch_cnt[k] < target && c < maxc) begin
            @(negedge clk); c++;
        end
        checks++;
        if (c >= maxc) begin
            errors++;
            $display("FAIL %s_timeout: fetches %0d, need %0d", nm, fetch_cnt[k], target);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        ch_en_i = 3'b001; ch_prio_i = 6'd0; ch_len_i = 9'd0;
        fmt_ready_i = 1'b1; auto_grant = 1'b0; man_grant = 1'b0;
        for (int n = 0; n < 4; n++) push(0, 32'hA000_0000 + 32'(n));
        rst_n_i = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({fmt_req_o, fmt_chid_o, fmt_len_o, busy_o, fmt_valid_o} !== {1'b1, 2'd0, 6'd4, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_req1: got req=%b chid=%0d len=%0d busy=%b vld=%b want 1 0 4 1 0",
                     fmt_req_o, fmt_chid_o, fmt_len_o, busy_o, fmt_valid_o);
        end
        @(negedge clk); #1;
        checks++;
        if (fmt_req_o !== 1'b1 || ch_fetch_o !== 3'b000) begin
            errors++;
            $display("FAIL single_req2: got req=%b fetch=%b want 1 000", fmt_req_o, ch_fetch_o);
        end
        man_grant = 1'b1;
        @(negedge clk);
        man_grant = 1'b0;
        #1;
        checks++;
        if (fmt_req_o !== 1'b0) begin
            errors++;
            $display("FAIL single_req_drop: got %b want 0", fmt_req_o);
        end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if ({fmt_valid_o, ch_fetch_o, fmt_end_o, fmt_data_o} !==
                {1'b1, 3'b001, (n == 3), 32'hA000_0000 + 32'(n)}) begin
                errors++;
                $display("FAIL single_word%0d: got vld=%b fetch=%b end=%b data=%h want 1 001 %0d %h",
                         n, fmt_valid_o, ch_fetch_o, fmt_end_o, fmt_data_o, (n == 3),
                         32'hA000_0000 + 32'(n));
            end
            @(negedge clk); #1;
        end
        checks++;
        if ({busy_o, fmt_valid_o, ch_fetch_o, fmt_chid_o, fmt_len_o} !== '0) begin
            errors++;
            $display("FAIL single_idle: got busy=%b vld=%b fetch=%b chid=%0d len=%0d want all 0",
                     busy_o, fmt_valid_o, ch_fetch_o, fmt_chid_o, fmt_len_o);
        end
    endtask

    task automatic check_packets(input int t, input int ob, input int gb, input int np,
                                 input int ord[4], input string nm);
        int seen[3] = '{0, 0, 0};
        checks++;
        if (grant_q.size() < gb + np || out_data.size() < ob + 4 * np) begin
            errors++;
            $display("FAIL %s_count: got grants %0d words %0d want %0d %0d", nm,
                     grant_q.size() - gb, out_data.size() - ob, np, 4 * np);
            return;
        end
        for (int p = 0; p < np; p++) begin
            checks++;
            if (grant_q[gb + p] !== 2'(ord[p])) begin
                errors++;
                $display("FAIL %s_grant%0d: got ch%0d want ch%0d", nm, p, grant_q[gb + p], ord[p]);
            end
            for (int j = 0; j < 4; j++) begin
                int i = ob + 4 * p + j;
                logic [34:0] exp = {2'(ord[p]), (j == 3), mkw(t, ord[p], seen[ord[p]] + j)};
                checks++;
                if ({out_ch[i], out_end[i], out_data[i]} !== exp) begin
                    errors++;
                    $display("FAIL %s_word%0d_%0d: got %h want %h", nm, p, j,
                             {out_ch[i], out_end[i], out_data[i]}, exp);
                end
            end
            seen[ord[p]] += 4;
        end
    endtask

    task automatic test_priority();
        int ob = out_data.size();
        int gb = grant_q.size();
        @(negedge clk);
        auto_grant = 1'b1;
        ch_en_i = 3'b111;
        ch_prio_i = {2'd3, 2'd1, 2'd2};
        ch_len_i = 9'd0;
        for (int k = 0; k < 3; k++) for (int n = 0; n < 4; n++) push(k, mkw(2, k, n));
        wait_done(ob + 12, 200, "prio");
        check_packets(2, ob, gb, 3, '{1, 0, 2, 0}, "prio");
    endtask

    task automatic test_round_robin();
        int ob = out_data.size();
        int gb = grant_q.size();
        int bb = bad_fetch;
        @(negedge clk);
        ch_prio_i = 6'd0;
        for (int n = 0; n < 8; n++) push(0, mkw(3, 0, n));
        for (int n = 0; n < 4; n++) begin push(1, mkw(3, 1, n)); push(2, mkw(3, 2, n)); end
        wait_done(ob + 16, 300, "rr");
        check_packets(3, ob, gb, 4, '{0, 1, 2, 0}, "rr");
        checks++;
        if (bad_fetch !== bb) begin
            errors++;
            $display("FAIL rr_bad_fetch: got %0d want %0d", bad_fetch, bb);
        end
    endtask

    task automatic test_backpressure();
        int fb = fetch_cnt[2];
        int ob = out_data.size();
        int bb = bad_fetch;
        int c = 0, hl = 0, viol = 0;
        bit started = 1'b0;
        @(negedge clk);
        ch_en_i = 3'b100;
        ch_len_i = {3'd1, 3'd0, 3'd0};
        fmt_ready_i = 1'b0;
        for (int n = 0; n < 8; n++) push(2, mkw(4, 2, n));
        while (c < 300 && !((fetch_cnt[2] - fb) == 8 && !busy_o)) begin
            @(negedge clk);
            fmt_ready_i = ~fmt_ready_i;
            if (!started && (fetch_cnt[2] - fb) == 5) begin started = 1'b1; hl = 3; end
            hold[2] = (hl > 0);
            if (hl > 0) hl--;
            #1;
            if (ch_fetch_o != 3'b000 && (hold[2] || !fmt_ready_i)) viol++;
            c++;
        end
        hold = 3'b000;
        fmt_ready_i = 1'b1;
        checks++;
        if ((fetch_cnt[2] - fb) != 8 || !started) begin
            errors++;
            $display("FAIL bp_fetches: got %0d (hold applied %0b) want 8", fetch_cnt[2] - fb, started);
        end
        checks++;
        if (viol != 0 || bad_fetch != bb) begin
            errors++;
            $display("FAIL bp_stall_fetch: got %0d stalled fetches %0d bad want 0 0", viol, bad_fetch - bb);
        end
        checks++;
        if (out_data.size() != ob + 8) begin
            errors++;
            $display("FAIL bp_words: got %0d want 8", out_data.size() - ob);
        end else begin
            for (int n = 0; n < 8; n++) begin
                checks++;
                if ({out_end[ob + n], out_data[ob + n]} !== {(n == 7), mkw(4, 2, n)}) begin
                    errors++;
                    $display("FAIL bp_word%0d: got %h want %h", n,
                             {out_end[ob + n], out_data[ob + n]}, {(n == 7), mkw(4, 2, n)});
                end
            end
        end
    endtask

    task automatic test_cfg_change();
        int fb = fetch_cnt[1];
        int ob = out_data.size();
        int gb = grant_q.size();
        @(negedge clk);
        ch_en_i = 3'b010;
        ch_len_i = {3'd0, 3'd2, 3'd0};
        for (int n = 0; n < 20; n++) push(1, mkw(5, 1, n));
        wait_fetch(1, fb + 3, 100, "cfg_start");
        ch_en_i = 3'b000;
        ch_len_i = 9'd0;
        ch_prio_i = 6'h3f;
        #1;
        checks++;
        if ({fmt_chid_o, fmt_len_o} !== {2'd1, 6'd16}) begin
            errors++;
            $display("FAIL cfg_latched: got chid=%0d len=%0d want 1 16", fmt_chid_o, fmt_len_o);
        end
        wait_done(ob + 16, 200, "cfg");
        checks++;
        if (out_data.size() != ob + 16) begin
            errors++;
            $display("FAIL cfg_words: got %0d want 16", out_data.size() - ob);
        end else begin
            for (int n = 0; n < 16; n++) begin
                checks++;
                if ({out_end[ob + n], out_data[ob + n]} !== {(n == 15), mkw(5, 1, n)}) begin
                    errors++;
                    $display("FAIL cfg_word%0d: got %h want %h", n,
                             {out_end[ob + n], out_data[ob + n]}, {(n == 15), mkw(5, 1, n)});
                end
            end
        end
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (grant_q.size() != gb + 1 || busy_o !== 1'b0 || (fetch_cnt[1] - fb) != 16) begin
            errors++;
            $display("FAIL cfg_disabled: got grants %0d busy %b fetches %0d want 1 0 16",
                     grant_q.size() - gb, busy_o, fetch_cnt[1] - fb);
        end
    endtask

    task automatic test_reset_mid();
        int fb, gb, c, viol;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        ch_en_i = 3'b001;
        ch_prio_i = 6'd0;
        ch_len_i = {3'd0, 3'd0, 3'd1};
        for (int n = 0; n < 8; n++) push(0, mkw(6, 0, n));
        wait_fetch(0, fetch_cnt[0] + 2, 100, "rstmid_start");
        rst_n_i = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL rstmid_async: got %h want 0", all_out);
        end
        fb = fetch_cnt[0] + fetch_cnt[1] + fetch_cnt[2];
        viol = 0;
        repeat (3) begin
            @(negedge clk); #1;
            if (ch_fetch_o != 3'b000) viol++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (viol != 0 || fetch_cnt[0] + fetch_cnt[1] + fetch_cnt[2] != fb) begin
            errors++;
            $display("FAIL rstmid_fetch: got %0d fetches during reset want 0",
                     fetch_cnt[0] + fetch_cnt[1] + fetch_cnt[2] - fb + viol);
        end
        ch_en_i = 3'b111;
        ch_len_i = 9'd0;
        for (int k = 0; k < 3; k++) for (int n = 0; n < 4; n++) push(k, mkw(7, k, n));
        gb = grant_q.size();
        rst_n_i = 1'b1;
        c = 0;
        while (grant_q.size() == gb && c < 50) begin @(negedge clk); c++; end
        checks++;
        if (grant_q.size() == gb) begin
            errors++;
            $display("FAIL rstmid_grant_timeout: got no grant want ch0");
        end else if (grant_q[gb] !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_tie: got ch%0d want ch0", grant_q[gb]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n_i = 1'b0;
        ch_en_i = 3'b000; ch_prio_i = 6'd0; ch_len_i = 9'd0;
        fmt_ready_i = 1'b0; auto_grant = 1'b0; man_grant = 1'b0;
        hold = 3'b000; flush = 1'b0;
        test_reset();
        test_single();
        test_priority();
        test_round_robin();
        test_backpressure();
        test_cfg_change();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
